// File: rtl/switch_ctrl_2x2.sv
// ============================================================================
// Module   : switch_ctrl_2x2
// Purpose  : Arbiter/sequencer for one registered 2x2 crossbar element.
//            Optional packet locking enabled by defining SWITCH_CTRL_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_ctrl_2x2 #(
  parameter int LATENCY = 2,
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] in_valid,
  input  logic [1:0] in_dest,
  input  logic [1:0] in_last,
  input  logic [1:0] out_ready,
  output logic [1:0] in_grant,
  output logic       select,
  output logic [1:0] out_valid
);

  logic       r_rr;
  logic       r_sel_hold;
  logic [1:0] r_pipe [LATENCY];

  logic [1:0] w_gnt;
  logic [1:0] w_rdy;
  logic [1:0] w_route;
  logic       w_cfg;
  logic       w_rr_toggle;
  logic       w_locked;

`ifdef SWITCH_CTRL_LOCK_EN
  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_STRAIGHT = 2'd1;
  localparam logic [1:0] c_CROSS    = 2'd2;

  logic [1:0] r_state;
  logic [1:0] r_act;
  logic [1:0] w_state_nxt;
  logic [1:0] w_act_nxt;

  assign w_locked = (r_state != c_IDLE);

  always_comb begin
    w_act_nxt = r_act;
    if (w_gnt[0]) w_act_nxt[0] = ~in_last[0];
    if (w_gnt[1]) w_act_nxt[1] = ~in_last[1];
    w_state_nxt = c_IDLE;
    if (w_act_nxt != 2'b00) w_state_nxt = w_cfg ? c_CROSS : c_STRAIGHT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_act   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_act   <= w_act_nxt;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^in_last;
  assign w_locked      = 1'b0;
`endif

  // Config 0 routes left->out0/right->out1; config 1 swaps them.
  always_comb begin
    w_gnt       = 2'b00;
    w_cfg       = 1'b0;
    w_rr_toggle = 1'b0;
    w_rdy[0]    = out_ready[in_dest[0]];
    w_rdy[1]    = out_ready[in_dest[1]];
`ifdef SWITCH_CTRL_LOCK_EN
    if (w_locked) begin
      w_cfg    = (r_state == c_CROSS);
      w_gnt[0] = in_valid[0] && (in_dest[0] == w_cfg)  && w_rdy[0];
      w_gnt[1] = in_valid[1] && (in_dest[1] == !w_cfg) && w_rdy[1];
    end else
`endif
    if (in_valid == 2'b11 && in_dest[0] != in_dest[1]) begin
      w_cfg = in_dest[0];
      w_gnt = w_rdy;
    end else if (in_valid == 2'b11) begin
      w_cfg = in_dest[r_rr] ^ r_rr;
      if (w_rdy[r_rr]) begin
        w_gnt       = r_rr ? 2'b10 : 2'b01;
        w_rr_toggle = 1'b1;
      end
    end else if (in_valid[0]) begin
      w_cfg    = in_dest[0];
      w_gnt[0] = w_rdy[0];
    end else if (in_valid[1]) begin
      w_cfg    = ~in_dest[1];
      w_gnt[1] = w_rdy[1];
    end
    if (!rst_n) begin
      w_gnt       = 2'b00;
      w_rr_toggle = 1'b0;
    end
  end

  assign in_grant = w_gnt;
  assign select   = (w_locked || (w_gnt != 2'b00)) ? w_cfg : r_sel_hold;

  assign w_route[0] = (w_gnt[0] & ~in_dest[0]) | (w_gnt[1] & ~in_dest[1]);
  assign w_route[1] = (w_gnt[0] &  in_dest[0]) | (w_gnt[1] &  in_dest[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= RR_INIT;
      r_sel_hold <= 1'b0;
    end else begin
      if (w_rr_toggle) r_rr <= ~r_rr;
      if (w_gnt != 2'b00) r_sel_hold <= select;
    end
  end

  // Valid flags travel alongside the switch's data pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= 2'b00;
    end else begin
      r_pipe[0] <= w_route;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign out_valid = r_pipe[LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_switch_ctrl_2x2.sv
// ============================================================================
// Module   : tb_switch_ctrl_2x2
// Purpose  : Directed self-checking bench for switch_ctrl_2x2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_ctrl_2x2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in_valid = 2'b00;
  logic [1:0] in_dest = 2'b00;
  logic [1:0] in_last = 2'b11;
  logic [1:0] out_ready = 2'b11;
  logic [1:0] in_grant;
  logic       select;
  logic [1:0] out_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_ctrl_2x2 #(.LATENCY(2), .RR_INIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .out_ready (out_ready),
    .in_grant  (in_grant),
    .select    (select),
    .out_valid (out_valid)
  );

  // Drive one cycle of inputs on the falling edge, then settle before checks.
  task automatic step(input logic [1:0] v, input logic [1:0] d,
                      input logic [1:0] l, input logic [1:0] r);
    @(negedge clk);
    in_valid = v; in_dest = d; in_last = l; out_ready = r;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 2'b00; in_dest = 2'b00; in_last = 2'b11; out_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 2'b11; in_dest = 2'b10; out_ready = 2'b11;
    #1;
    checks++; if (in_grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", in_grant); end
    checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
    checks++; if (select !== 1'b0) begin failures++; $display("FAIL reset_select got=%b exp=0", select); end
    do_reset();
  endtask

  task automatic test_straight_pair;
    logic [1:0] exp_ov;
    step(2'b11, 2'b10, 2'b11, 2'b11);
    checks++; if (in_grant !== 2'b11) begin failures++; $display("FAIL straight_grant got=%b exp=11", in_grant); end
    checks++; if (select !== 1'b0) begin failures++; $display("FAIL straight_select got=%b exp=0", select); end
    for (int c = 1; c <= 3; c++) begin
      step(2'b00, 2'b00, 2'b11, 2'b11);
      exp_ov = (c == 2) ? 2'b11 : 2'b00;
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL straight_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov); end
    end
  endtask

  task automatic test_rr_same_dest;
    logic [1:0] exp_g, exp_ov;
    logic       exp_s;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step((c < 4) ? 2'b11 : 2'b00, 2'b00, 2'b11, 2'b11);
      if (c < 4) begin
        exp_g = (c % 2 == 1) ? 2'b10 : 2'b01;
        exp_s = (c % 2 == 1);
        checks++; if (in_grant !== exp_g) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, in_grant, exp_g); end
        checks++; if (select !== exp_s) begin failures++; $display("FAIL rr_select c=%0d got=%b exp=%b", c, select, exp_s); end
      end
      exp_ov = (c >= 2 && c < 6) ? 2'b01 : 2'b00;
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL rr_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov); end
    end
  endtask

  task automatic test_ready_block;
    do_reset();
    step(2'b01, 2'b01, 2'b11, 2'b01);
    checks++; if (in_grant !== 2'b00) begin failures++; $display("FAIL ready_block_grant got=%b exp=00", in_grant); end
    checks++; if (select !== 1'b0) begin failures++; $display("FAIL ready_block_select got=%b exp=0", select); end
    step(2'b01, 2'b01, 2'b11, 2'b11);
    checks++; if (in_grant !== 2'b01) begin failures++; $display("FAIL ready_open_grant got=%b exp=01", in_grant); end
    checks++; if (select !== 1'b1) begin failures++; $display("FAIL ready_open_select got=%b exp=1", select); end
  endtask

  task automatic test_idle_hold;
    logic [1:0] exp_ov;
    do_reset();
    step(2'b10, 2'b00, 2'b11, 2'b11);
    checks++; if (in_grant !== 2'b10) begin failures++; $display("FAIL hold_first_grant got=%b exp=10", in_grant); end
    checks++; if (select !== 1'b1) begin failures++; $display("FAIL hold_first_select got=%b exp=1", select); end
    for (int c = 1; c <= 5; c++) begin
      step(2'b00, 2'b00, 2'b11, 2'b11);
      exp_ov = (c == 2) ? 2'b01 : 2'b00;
      checks++; if (select !== 1'b1) begin failures++; $display("FAIL hold_select c=%0d got=%b exp=1", c, select); end
      checks++; if (in_grant !== 2'b00) begin failures++; $display("FAIL hold_grant c=%0d got=%b exp=00", c, in_grant); end
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL hold_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov); end
    end
  endtask

  task automatic test_cross_pair;
    do_reset();
    step(2'b11, 2'b01, 2'b11, 2'b11);
    checks++; if (in_grant !== 2'b11) begin failures++; $display("FAIL cross_grant got=%b exp=11", in_grant); end
    checks++; if (select !== 1'b1) begin failures++; $display("FAIL cross_select got=%b exp=1", select); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      step(2'b01, 2'b00, 2'b00, 2'b11);
      checks++; if (in_grant !== 2'b01) begin failures++; $display("FAIL midrst_flit_grant c=%0d got=%b exp=01", c, in_grant); end
    end
    @(negedge clk);
    rst_n = 1'b0; in_valid = 2'b01;
    #1;
    checks++; if (in_grant !== 2'b00) begin failures++; $display("FAIL midrst_grant got=%b exp=00", in_grant); end
    checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL midrst_out_valid got=%b exp=00", out_valid); end
    checks++; if (select !== 1'b0) begin failures++; $display("FAIL midrst_select got=%b exp=0", select); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 2'b10; in_dest = 2'b00; in_last = 2'b11;
    #1;
    checks++; if (in_grant !== 2'b10) begin failures++; $display("FAIL midrst_after_grant got=%b exp=10", in_grant); end
    checks++; if (select !== 1'b1) begin failures++; $display("FAIL midrst_after_select got=%b exp=1", select); end
  endtask

`ifdef SWITCH_CTRL_LOCK_EN
  task automatic test_lock_hold;
    do_reset();
    step(2'b01, 2'b00, 2'b00, 2'b11);
    checks++; if (in_grant !== 2'b01) begin failures++; $display("FAIL lock_c0_grant got=%b exp=01", in_grant); end
    step(2'b11, 2'b00, 2'b00, 2'b11);
    checks++; if (in_grant !== 2'b01) begin failures++; $display("FAIL lock_c1_grant got=%b exp=01", in_grant); end
    step(2'b11, 2'b00, 2'b01, 2'b11);
    checks++; if (in_grant !== 2'b01) begin failures++; $display("FAIL lock_c2_grant got=%b exp=01", in_grant); end
    checks++; if (out_valid !== 2'b01) begin failures++; $display("FAIL lock_c2_out_valid got=%b exp=01", out_valid); end
    step(2'b10, 2'b00, 2'b10, 2'b11);
    checks++; if (in_grant !== 2'b10) begin failures++; $display("FAIL lock_c3_grant got=%b exp=10", in_grant); end
    checks++; if (select !== 1'b1) begin failures++; $display("FAIL lock_c3_select got=%b exp=1", select); end
  endtask

  task automatic test_lock_parallel;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(2'b11, 2'b10, {1'b1, (c == 2)}, 2'b11);
      checks++; if (in_grant !== 2'b11) begin failures++; $display("FAIL par_grant c=%0d got=%b exp=11", c, in_grant); end
      checks++; if (select !== 1'b0) begin failures++; $display("FAIL par_select c=%0d got=%b exp=0", c, select); end
    end
  endtask

  task automatic test_lock_stall;
    do_reset();
    step(2'b01, 2'b01, 2'b00, 2'b11);
    checks++; if (in_grant !== 2'b01) begin failures++; $display("FAIL stall_c0_grant got=%b exp=01", in_grant); end
    checks++; if (select !== 1'b1) begin failures++; $display("FAIL stall_c0_select got=%b exp=1", select); end
    for (int c = 1; c <= 2; c++) begin
      step(2'b11, 2'b11, 2'b00, 2'b01);
      checks++; if (in_grant !== 2'b00) begin failures++; $display("FAIL stall_grant c=%0d got=%b exp=00", c, in_grant); end
      checks++; if (select !== 1'b1) begin failures++; $display("FAIL stall_select c=%0d got=%b exp=1", c, select); end
    end
    for (int c = 3; c <= 5; c++) begin
      step(2'b11, 2'b11, (c == 5) ? 2'b11 : 2'b10, 2'b11);
      checks++; if (in_grant !== 2'b01) begin failures++; $display("FAIL stall_resume_grant c=%0d got=%b exp=01", c, in_grant); end
    end
    step(2'b10, 2'b11, 2'b11, 2'b11);
    checks++; if (in_grant !== 2'b10) begin failures++; $display("FAIL stall_release_grant got=%b exp=10", in_grant); end
    checks++; if (select !== 1'b0) begin failures++; $display("FAIL stall_release_select got=%b exp=0", select); end
  endtask
`endif

  initial begin
    test_reset();
    test_straight_pair();
    test_rr_same_dest();
    test_ready_block();
    test_idle_hold();
    test_cross_pair();
    test_mid_reset();
`ifdef SWITCH_CTRL_LOCK_EN
    test_lock_hold();
    test_lock_parallel();
    test_lock_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
